fp_div_seq: RTL and testbench

//  Sequential IEEE-754 single-precision divider: out = para1 / para2. It is the inverse-operation companion of the

---
 rtl/fp_div_seq.sv | 211 +++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: out = para1 / para2, radix-2 restoring mantissa loop.
// Latency: out_valid rises 27 edges after accept (MAN_W+3 quotient bits + 1 normalise); specials go straight to DONE.
// Backpressure: one op in flight; result held stable until out_ready, in_ready low until then. Macro: DIV_ROUND_NEAREST_EN.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   para1,
  input  logic [EXP_W+MAN_W:0]   para2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   under_overflow
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;          // mantissa incl. hidden bit
  localparam int RW = MAN_W + 2;          // partial remainder width
  localparam int QW = MAN_W + 3;          // quotient bits / loop iterations
  localparam int EW = EXP_W + 2;          // signed working exponent
  localparam int CW = $clog2(QW);

  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]        LAST = CW'(QW - 1);
  localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [MW-1:0]          m2_q, m2_d;
  logic [RW-1:0]          rem_q, rem_d;
  logic [QW-1:0]          quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           out_q, out_d;
  logic                   flag_q, flag_d;

  // Operand decode; exponent field of zero means the operand is treated as zero.
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic             z1, z2, inf1, inf2, nan1, nan2, sign_in, special;
  logic signed [EW-1:0] exp_in;
  logic [W-1:0]     spec_res;
  logic             spec_flag;

  assign e1 = para1[W-2:MAN_W];
  assign e2 = para2[W-2:MAN_W];
  assign f1 = para1[MAN_W-1:0];
  assign f2 = para2[MAN_W-1:0];
  assign z1   = (e1 == '0);
  assign z2   = (e2 == '0);
  assign inf1 = (e1 == '1) && (f1 == '0);
  assign inf2 = (e2 == '1) && (f2 == '0);
  assign nan1 = (e1 == '1) && (f1 != '0);
  assign nan2 = (e2 == '1) && (f2 != '0);
  assign sign_in = para1[W-1] ^ para2[W-1];
  assign special = nan1 | nan2 | z1 | z2 | inf1 | inf2;
  assign exp_in  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS;

  // Special-operand result, resolved in priority order at accept time.
  always_comb begin
    spec_res  = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    spec_flag = 1'b0;
    if (nan1 | nan2 | (z1 & z2) | (inf1 & inf2)) begin
      spec_res = QNAN;
    end else if (inf1) begin
      spec_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf2 | z1) begin
      spec_res = {sign_in, {(W-1){1'b0}}};
    end else begin
      spec_flag = 1'b1;                   // finite nonzero / 0
    end
  end

  // One restoring step: subtract divisor if it fits, then shift the remainder.
  logic [RW:0]   diff;
  logic          ge;
  logic [RW-1:0] rem_sel, rem_step;

  assign diff     = {1'b0, rem_q} - {2'b00, m2_q};
  assign ge       = ~diff[RW];
  assign rem_sel  = ge ? diff[RW-1:0] : rem_q;
  assign rem_step = rem_sel << 1;

  // Normalise (quotient lies in [0.5,2)), round, and range-check.
  logic                 norm_shift, round_up;
  logic [MW-1:0]        mant_n;
  logic [MW:0]          mant_r;
  logic [MAN_W-1:0]     frac_f;
  logic signed [EW-1:0] exp_n, exp_f;
  logic [W-1:0]         norm_res;
  logic                 norm_flag;

  assign norm_shift = ~quo_q[QW-1];
  assign mant_n     = norm_shift ? quo_q[QW-2:1] : quo_q[QW-1:2];
  assign exp_n      = exp_q - EW'(norm_shift);

`ifdef DIV_ROUND_NEAREST_EN
  logic guard, sticky;
  assign guard    = norm_shift ? quo_q[0] : quo_q[1];
  assign sticky   = (~norm_shift & quo_q[0]) | (|rem_q);
  assign round_up = guard & (sticky | mant_n[0]);
`else
  assign round_up = 1'b0;
`endif

  assign mant_r = {1'b0, mant_n} + {{MW{1'b0}}, round_up};
  // A carry out of rounding means the mantissa became 2.0: renormalise to 1.0 and bump the exponent.
  assign frac_f = mant_r[MW] ? mant_r[MW-1:1] : mant_r[MAN_W-1:0];
  assign exp_f  = exp_n + EW'(mant_r[MW]);

  always_comb begin
    norm_res  = {sign_q, exp_f[EXP_W-1:0], frac_f};
    norm_flag = 1'b0;
    if (exp_f >= EMAX) begin
      norm_res  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flag = 1'b1;
    end else if (exp_f[EW-1] || (exp_f == '0)) begin
      norm_res  = {sign_q, {(W-1){1'b0}}};
      norm_flag = 1'b1;
    end
  end

  assign in_ready       = rst_n && (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign out            = out_q;
  assign under_overflow = flag_q;

  // Next-state and datapath update for the accept / divide / normalise / hold sequence.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    m2_d    = m2_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flag_d  = flag_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d = sign_in;
          if (special) begin
            out_d   = spec_res;
            flag_d  = spec_flag;
            state_d = DONE;
          end else begin
            exp_d   = exp_in;
            m2_d    = {1'b1, f2};
            rem_d   = {1'b0, 1'b1, f1};
            quo_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = rem_step;
        quo_d = {quo_q[QW-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = NORM;
      end
      NORM: begin
        out_d   = norm_res;
        flag_d  = norm_flag;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      m2_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      m2_q   <= m2_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: reset, normal quotients, range limits, specials,
// backpressure, reset mid-divide. Latency is counted in edges after the accept edge.
// Expected values are hand-computed IEEE-754 bit patterns.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, under_overflow;
  logic [31:0] para1, para2, out;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .para1(para1), .para2(para2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .under_overflow(under_overflow)
  );

  // Present one operation at the next edge, then count edges until out_valid (bounded).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic rdy_seen);
    para1 = a; para2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; para1 = '0; para2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=00000000", out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (under_overflow !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", under_overflow); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_normal();
    logic [31:0] a [7];
    logic [31:0] b [7];
    logic [31:0] q [7];
    logic        f [7];
    int          lat;
    logic        rdy;
    a = '{32'h40C00000, 32'h3F800000, 32'hC1200000, 32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h3F800000};
    b = '{32'h40000000, 32'h40400000, 32'h40A00000, 32'h3FC00000, 32'h00800000, 32'h7F000000, 32'h3F7FFFFF};
`ifdef DIV_ROUND_NEAREST_EN
    q = '{32'h40400000, 32'h3EAAAAAB, 32'hC0000000, 32'h3F800000, 32'h7F800000, 32'h00000000, 32'h3F800001};
`else
    q = '{32'h40400000, 32'h3EAAAAAA, 32'hC0000000, 32'h3F800000, 32'h7F800000, 32'h00000000, 32'h3F800000};
`endif
    f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(a[i], b[i], lat, rdy);
      checks++; if (lat !== 27) begin failures++; $display("FAIL normal_latency[%0d] got=%0d exp=27", i, lat); end
      checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL normal_in_ready_busy[%0d] got=%b exp=0", i, rdy); end
      checks++; if (out !== q[i]) begin failures++; $display("FAIL normal_out[%0d] %h/%h got=%h exp=%h", i, a[i], b[i], out, q[i]); end
      checks++; if (under_overflow !== f[i]) begin failures++; $display("FAIL normal_flag[%0d] got=%b exp=%b", i, under_overflow, f[i]); end
      consume();
    end
  endtask

  task automatic test_specials();
    logic [31:0] a [9];
    logic [31:0] b [9];
    logic [31:0] q [9];
    logic        f [9];
    int          lat;
    logic        rdy;
    a = '{32'hBF800000, 32'h00000000, 32'h7F800000, 32'h40000000, 32'h7F800001,
          32'h7F800000, 32'h80000000, 32'h00000001, 32'h3F800000};
    b = '{32'h00000000, 32'h00000000, 32'h40000000, 32'hFF800000, 32'h3F800000,
          32'hFF800000, 32'h40000000, 32'h3F800000, 32'h00400000};
    q = '{32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h7FC00000,
          32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7F800000};
    f = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      run_op(a[i], b[i], lat, rdy);
      // Result is registered at the accept edge, so out_valid is already high in the very next cycle.
      checks++; if (lat !== 0) begin failures++; $display("FAIL special_latency[%0d] got=%0d edges exp=0 (valid next cycle)", i, lat); end
      checks++; if (out !== q[i]) begin failures++; $display("FAIL special_out[%0d] %h/%h got=%h exp=%h", i, a[i], b[i], out, q[i]); end
      checks++; if (under_overflow !== f[i]) begin failures++; $display("FAIL special_flag[%0d] got=%b exp=%b", i, under_overflow, f[i]); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic rdy;
    run_op(32'h40C00000, 32'h40000000, lat, rdy);
    checks++; if (lat !== 27) begin failures++; $display("FAIL bp_latency got=%0d exp=27", lat); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out !== 32'h40400000 || under_overflow !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got vld=%b out=%h flag=%b rdy=%b exp vld=1 out=40400000 flag=0 rdy=0",
                 i, out_valid, out, under_overflow, in_ready);
      end
    end
    // Offer a new op during the handshake cycle; it must not be taken.
    para1 = 32'h3F800000; para2 = 32'h40400000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic rdy;
    logic seen;
    para1 = 32'h40C00000; para2 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out !== 32'h0) begin failures++; $display("FAIL midrst_out got=%h exp=00000000", out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_result got=%b exp=0", seen); end
    run_op(32'h40C00000, 32'h40000000, lat, rdy);
    checks++; if (lat !== 27) begin failures++; $display("FAIL midrst_latency got=%0d exp=27", lat); end
    checks++; if (out !== 32'h40400000) begin failures++; $display("FAIL midrst_out2 got=%h exp=40400000", out); end
    checks++; if (under_overflow !== 1'b0) begin failures++; $display("FAIL midrst_flag2 got=%b exp=0", under_overflow); end
    consume();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
